// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
//   Operands are split into BLOCK-bit groups; group k is resolved by a flat
//   two-level lookahead in pipeline stage k, and its carry-out is registered
//   into stage k+1. Latency is N = WIDTH/BLOCK cycles, throughput one op/cycle.
//   Optional feature macro: CLA_PIPE_FLAGS_EN adds registered ovf/zero outputs.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready = !out_valid || out_ready, so the input side never waits on
// anything but the consumer. Once out_valid rises, s/cout (and the flags)
// stay stable until the edge where out_ready is also high.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int N = WIDTH / BLOCK;

  // Carries of one group as a flat sum of products:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..1]g[0] | p[i..0]c0
  // Each term is built from g, p and c0 only, never from a lower carry.
  function automatic logic [BLOCK:0] group_carries(input logic [BLOCK-1:0] g,
                                                   input logic [BLOCK-1:0] p,
                                                   input logic             c0);
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c0;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Pipeline registers, one entry per stage. Stage k holds the sum bits
  // resolved through group k and the still-unresolved upper operand bits
  // (resolved bits are cleared, so they fold away as constants).
  logic             vld_q [N];
  logic             cry_q [N];
  logic [WIDTH-1:0] sum_q [N];
  logic [WIDTH-1:0] opa_q [N];
  logic [WIDTH-1:0] opb_q [N];

  logic             cry_d [N];
  logic [WIDTH-1:0] sum_d [N];
  logic [WIDTH-1:0] opa_d [N];
  logic [WIDTH-1:0] opb_d [N];

  // Inputs seen by each stage: conditioned operands for stage 0,
  // the previous stage register otherwise.
  logic             stg_c [N];
  logic [WIDTH-1:0] stg_s [N];
  logic [WIDTH-1:0] stg_a [N];
  logic [WIDTH-1:0] stg_b [N];

`ifdef CLA_PIPE_FLAGS_EN
  logic msb_cry_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;
`endif

  logic adv;

  assign adv       = !vld_q[N-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[N-1];
  assign s         = sum_q[N-1];
  assign cout      = cry_q[N-1];

  for (genvar k = 0; k < N; k++) begin : g_link
    if (k == 0) begin : g_head
      // Subtraction is A + ~B + 1; cin is ignored when sub=1.
      assign stg_a[k] = a;
      assign stg_b[k] = sub ? ~b : b;
      assign stg_c[k] = sub ? 1'b1 : cin;
      assign stg_s[k] = '0;
    end else begin : g_tail
      assign stg_a[k] = opa_q[k-1];
      assign stg_b[k] = opb_q[k-1];
      assign stg_c[k] = cry_q[k-1];
      assign stg_s[k] = sum_q[k-1];
    end
  end

  // Resolve group k in stage k and form every stage's next register contents.
  always_comb begin : comb_stages
    logic [BLOCK-1:0] grp_a;
    logic [BLOCK-1:0] grp_b;
    logic [BLOCK-1:0] grp_g;
    logic [BLOCK-1:0] grp_p;
    logic [BLOCK:0]   grp_c;
    logic [WIDTH-1:0] upper_mask;
`ifdef CLA_PIPE_FLAGS_EN
    msb_cry_d = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      grp_a      = stg_a[k][k*BLOCK +: BLOCK];
      grp_b      = stg_b[k][k*BLOCK +: BLOCK];
      grp_g      = grp_a & grp_b;
      grp_p      = grp_a ^ grp_b;
      grp_c      = group_carries(grp_g, grp_p, stg_c[k]);
      upper_mask = {WIDTH{1'b1}} << ((k + 1) * BLOCK);

      sum_d[k]                     = stg_s[k];
      sum_d[k][k*BLOCK +: BLOCK]   = grp_p ^ grp_c[BLOCK-1:0];
      cry_d[k]                     = grp_c[BLOCK];
      opa_d[k]                     = stg_a[k] & upper_mask;
      opb_d[k]                     = stg_b[k] & upper_mask;
`ifdef CLA_PIPE_FLAGS_EN
      // Carry into the MSB lives in the last group, one below its carry-out.
      if (k == N - 1) msb_cry_d = grp_c[BLOCK-1];
`endif
    end
`ifdef CLA_PIPE_FLAGS_EN
    zero_d = ~|sum_d[N-1];
`endif
  end

  // Shift every stage forward together when the output can move; hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        sum_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
`ifdef CLA_PIPE_FLAGS_EN
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`endif
    end else if (adv) begin
      vld_q[0] <= in_valid && in_ready;
      for (int k = 1; k < N; k++) vld_q[k] <= vld_q[k-1];
      for (int k = 0; k < N; k++) begin
        cry_q[k] <= cry_d[k];
        sum_q[k] <= sum_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
`ifdef CLA_PIPE_FLAGS_EN
      ovf_q  <= msb_cry_d ^ cry_d[N-1];
      zero_q <= zero_d;
`endif
    end
  end

`ifdef CLA_PIPE_FLAGS_EN
  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule
